hilo_md_sched: RTL
==================

// Module: hilo_md_sched
// PURPOSE
//  Issue scheduler for the multi-cycle multiply/divide core in the E stage. Owns the
//  architectural HI/LO registers. Launches the core with a start/done handshake.
//  Enforces the fixed architectural latency and commits results into HI/LO.
//  Generates the D-stage stall for any HILO-using instruction while the unit is occupied.
// PARAMETERS
//  MULT_CYCLES  5   issue-to-commit latency for mult/multu; must be >= 1
//  DIV_CYCLES   10  issue-to-commit latency for div/divu; must be >= 1
//  CNT_W        4   latency counter width; 2**CNT_W must exceed max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high
//  e_valid    in   1   E-stage instruction valid
//  e_op       in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO; 9-15 treated as NONE
//  e_rs       in   32  rs operand; also the mthi/mtlo data
//  e_rt       in   32  rt operand
//  d_md_use   in   1   D-stage instruction is any of op codes 1-8
//  core_start out  1   one-cycle launch pulse to the arithmetic core
//  core_op    out  2   {is_div, is_unsigned}; held stable while busy
//  core_a     out  32  latched rs; held stable while busy
//  core_b     out  32  latched rt; held stable while busy
//  core_done  in   1   core result-valid pulse
//  core_hi    in   32  core HI result (remainder for div); sampled only with core_done
//  core_lo    in   32  core LO result (quotient for div); sampled only with core_done
//  result     out  32  MFHI ? HI : MFLO ? LO : 0; combinational on e_op
//  busy       out  1   issue_now | (state != IDLE)
//  stall_d    out  1   d_md_use & busy
//  err        out  1   sticky: MTHI/MTLO/start seen while not IDLE
// BEHAVIOUR
//  Reset values
//   - Registers: state=IDLE, HI=LO=0, cnt=0, got=0, err=0, core_a=core_b=0, core_op=0.
//   - Outputs: core_start=0.
//  issue_now = e_valid & e_op in {1..4}.
//  IDLE
//   - issue_now: latch core_a/core_b/core_op, pulse core_start this edge.
//   - issue_now: cnt <= N-1 (N = MULT_CYCLES or DIV_CYCLES), got <= 0, state <= RUN.
//   - MTHI: HI <= e_rs. MTLO: LO <= e_rs. Both take effect at the edge.
//   - core_done is ignored (stray pulse after reset or after commit).
//  RUN
//   - Each edge: if cnt != 0, cnt <= cnt-1.
//   - core_done at an edge: res_hi/res_lo <= core_hi/core_lo and got <= 1. First pulse only; later pulses ignored.
//   - Commit edge: cnt == 0 and (got | core_done). Commit writes HI/LO (core_* directly if core_done this edge).
//   - Commit edge: state <= IDLE.
//   - cnt == 0 and no result yet: hold RUN, counter frozen, until core_done. Then commit at that same edge.
//  Timing: op sampled at edge T0 with an on-time core gives a commit at edge T0+N. busy is high from the issue
//   cycle up to and including the cycle before commit; HI/LO carry new values from T0+N.
//  Other ops while RUN
//   - Any start, MTHI or MTLO seen while RUN is not executed and sets err.
//   - The pipeline must prevent this via stall_d.
//  MFHI/MFLO: result is the committed HI/LO only; no forwarding of in-flight results.
//  Divide-by-zero values are the core's responsibility; the scheduler commits whatever the core returns.
//  Reset mid-operation
//   - Returns to IDLE and zeroes HI/LO.
//   - No commit; core_start stays 0; a pending core_done is ignored.
// TESTING
//  1. MULT 7*-3, core_done at T0+2 -> core_start 1 cycle at T0; busy 1 through T0+4.
//     HI=0xFFFFFFFF, LO=0xFFFFFFEB from T0+5.
//  2. DIVU 100/7, core_done late at T0+12 -> no commit at T0+10; commit at T0+12.
//     HI=2, LO=14, busy low after T0+12.
//  3. MTHI 0x1234 then MFHI next cycle, idle -> result=0x00001234; busy stays 0, core_start never 1.
//  4. MULT issued at T0, d_md_use=1 for MFLO in D -> stall_d=1 from T0 through T0+4.
//     stall_d=0 at T0+5; MFLO then reads the new LO.
//  5. DIV issued, reset at T0+3, core_done at T0+4 -> HI=LO=0, busy=0 from T0+4.
//     The stray done leaves HI/LO unchanged.
//  6. Force MTLO 0x55 while RUN -> LO unchanged and err=1. err stays 1 until reset.

Source files
------------

// File: rtl/hilo_md_sched_if.sv
// Handshake bundle between the HI/LO issue scheduler and the multiply/divide core.
interface hilo_md_sched_if;
  logic        core_start;
  logic [1:0]  core_op;     // {is_div, is_unsigned}
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_done;
  logic [31:0] core_hi;
  logic [31:0] core_lo;

  // Scheduler side: launches work, receives results.
  modport master (
    output core_start, core_op, core_a, core_b,
    input  core_done, core_hi, core_lo
  );

  // Arithmetic core side.
  modport slave (
    input  core_start, core_op, core_a, core_b,
    output core_done, core_hi, core_lo
  );
endinterface

// File: rtl/hilo_md_sched.sv
// Issue scheduler for the multi-cycle mul/div core. Owns HI/LO, enforces the fixed
// architectural latency, commits results and stalls D-stage HI/LO users while occupied.
module hilo_md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  e_valid,
  input  logic [3:0]            e_op,
  input  logic [31:0]           e_rs,
  input  logic [31:0]           e_rt,
  input  logic                  d_md_use,
  hilo_md_sched_if.master       core,
  output logic [31:0]           result,
  output logic                  busy,
  output logic                  stall_d,
  output logic                  err
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  // Counter reload is N-1 so that the commit lands exactly N edges after issue.
  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             got_q;
  logic             err_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      res_hi_q, res_lo_q;
  logic             start_q;
  logic [1:0]       op_q;
  logic [31:0]      a_q, b_q;

  logic             issue_now;
  logic             is_div;
  logic             is_mthi;
  logic             is_mtlo;
  logic             commit;

  // Decode the E-stage instruction and the commit condition.
  always_comb begin
    issue_now = e_valid & (e_op == OpMult || e_op == OpMultu ||
                           e_op == OpDiv  || e_op == OpDivu);
    is_div    = (e_op == OpDiv) || (e_op == OpDivu);
    is_mthi   = e_valid & (e_op == OpMthi);
    is_mtlo   = e_valid & (e_op == OpMtlo);
    // A late core_done commits at the same edge it arrives.
    commit    = (state_q == StRun) && (cnt_q == '0) && (got_q || core.core_done);
  end

  // Scheduler FSM with registered launch outputs and HI/LO state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      got_q    <= 1'b0;
      err_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      start_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (issue_now) begin
            op_q    <= {is_div, (e_op == OpMultu) || (e_op == OpDivu)};
            a_q     <= e_rs;
            b_q     <= e_rt;
            start_q <= 1'b1;
            cnt_q   <= is_div ? DivLoad : MultLoad;
            got_q   <= 1'b0;
            state_q <= StRun;
          end else if (is_mthi) begin
            hi_q <= e_rs;
          end else if (is_mtlo) begin
            lo_q <= e_rs;
          end
        end
        StRun: begin
          // Anything that would disturb the in-flight operation is dropped and flagged.
          if (issue_now || is_mthi || is_mtlo) begin
            err_q <= 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
          if (core.core_done && !got_q) begin
            res_hi_q <= core.core_hi;
            res_lo_q <= core.core_lo;
            got_q    <= 1'b1;
          end
          if (commit) begin
            hi_q    <= got_q ? res_hi_q : core.core_hi;
            lo_q    <= got_q ? res_lo_q : core.core_lo;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs: core launch bundle, committed-register read mux and occupancy.
  always_comb begin
    core.core_start = start_q;
    core.core_op    = op_q;
    core.core_a     = a_q;
    core.core_b     = b_q;
    result          = (e_op == OpMfhi) ? hi_q : (e_op == OpMflo) ? lo_q : 32'd0;
    busy            = issue_now | (state_q != StIdle);
    stall_d         = d_md_use & busy;
    err             = err_q;
  end

endmodule
